// File: rtl/ft_rx_gateway.sv
// FT60x 245-mode receive gateway: bus read FSM feeding a first-word-fall-through FIFO.
// Optional FT_RX_BYTE_COUNT_EN adds byte_count_out (byte total of accepted transfers).
module ft_rx_gateway #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned STOP_MARGIN = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rxf_n_in,
    input  logic [31:0] data_in,
    input  logic [3:0]  be_in,
    output logic        oe_n_out,
    output logic        rd_n_out,
    output logic [31:0] data_out,
    output logic [3:0]  be_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        busy_out
`ifdef FT_RX_BYTE_COUNT_EN
    ,
    output logic [31:0] byte_count_out
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        READ = 2'd2,
        STOP = 2'd3
    } state_t;

    // Reset asserts asynchronously, releases two clocks after rst_n_in rises.
    logic [1:0] rst_sync_q;
    logic       rst_sync_n;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    state_t        state_q;
    logic          oe_n_q;
    logic          rd_n_q;
    logic          busy_q;
    word_t         mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    logic [CW-1:0] free_c;
    logic          room_ok_c;
    logic          full_c;
    logic          capture_c;
    logic          wr_en_c;
    logic          rd_en_c;
    word_t         head_c;

    assign free_c    = CW'(FIFO_DEPTH) - count_q;
    assign room_ok_c = (free_c >= CW'(STOP_MARGIN));
    assign full_c    = (count_q == CW'(FIFO_DEPTH));
    assign capture_c = (state_q == READ) && !rxf_n_in;
    assign rd_en_c   = valid_out && ready_in;
    // A pop on the same edge frees the slot, so a full FIFO can still take the word.
    assign wr_en_c   = capture_c && (be_in != 4'h0) && (!full_c || rd_en_c);
    assign head_c    = mem_q[rd_ptr_q];

    // The edge that first sees free < STOP_MARGIN still captures; the margin absorbs it.
    always_ff @(posedge clk_in or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= IDLE;
            oe_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rxf_n_in && room_ok_c) begin
                        state_q <= TURN;
                        oe_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                TURN: begin
                    state_q <= READ;
                    rd_n_q  <= 1'b0;
                end
                READ: begin
                    if (rxf_n_in || !room_ok_c) begin
                        state_q <= STOP;
                        rd_n_q  <= 1'b1;
                    end
                end
                STOP: begin
                    state_q <= IDLE;
                    oe_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    oe_n_q  <= 1'b1;
                    rd_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage is cleared on reset so data_out/be_out read zero while empty after reset.
    always_ff @(posedge clk_in or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en_c) begin
                mem_q[wr_ptr_q] <= word_t'({be_in, data_in});
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (rd_en_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(wr_en_c) - CW'(rd_en_c);
        end
    end

    assign oe_n_out  = oe_n_q;
    assign rd_n_out  = rd_n_q;
    assign busy_out  = busy_q;
    assign valid_out = (count_q != '0);
    assign data_out  = head_c.data;
    assign be_out    = head_c.be;

`ifdef FT_RX_BYTE_COUNT_EN
    logic [31:0] byte_count_q;
    logic [31:0] be_pop_c;

    assign be_pop_c = 32'(be_out[0]) + 32'(be_out[1]) + 32'(be_out[2]) + 32'(be_out[3]);

    always_ff @(posedge clk_in or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            byte_count_q <= '0;
        end else if (rd_en_c) begin
            byte_count_q <= byte_count_q + be_pop_c;
        end
    end

    assign byte_count_out = byte_count_q;
`endif

endmodule

// File: tb/tb_ft_rx_gateway.sv
// Bench for ft_rx_gateway: FT60x source model feeding a scoreboard checked at the user port.
module tb_ft_rx_gateway;

    localparam int unsigned FIFO_DEPTH  = 16;
    localparam int unsigned STOP_MARGIN = 4;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } word_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rxf_n_in;
    logic [31:0] data_in;
    logic [3:0]  be_in;
    logic        oe_n_out;
    logic        rd_n_out;
    logic [31:0] data_out;
    logic [3:0]  be_out;
    logic        valid_out;
    logic        ready_in;
    logic        busy_out;
`ifdef FT_RX_BYTE_COUNT_EN
    logic [31:0] byte_count_out;
`endif

    always #5 clk_in = ~clk_in;

    ft_rx_gateway #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .STOP_MARGIN (STOP_MARGIN)
    ) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .rxf_n_in  (rxf_n_in),
        .data_in   (data_in),
        .be_in     (be_in),
        .oe_n_out  (oe_n_out),
        .rd_n_out  (rd_n_out),
        .data_out  (data_out),
        .be_out    (be_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .busy_out  (busy_out)
`ifdef FT_RX_BYTE_COUNT_EN
        ,
        .byte_count_out (byte_count_out)
`endif
    );

    word_t      src_q[$];
    word_t      sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         taken   = 0;
    int         delivered = 0;
    logic [3:0] last_be_out = 4'h0;
    bit         force_rxf = 1'b0;
    bit         lat_chk   = 1'b0;
    bit         lat_pend  = 1'b0;

    // One bus cycle: present source word, account for the coming edge, step past it.
    task automatic tick();
        word_t w;
        word_t exp_w;
        bit    take;
        bit    xfer;
        if (lat_chk && lat_pend) begin
            n_tests++;
            if (valid_out !== 1'b1) begin
                n_fail++;
                $display("FAIL latency: valid_out=%b one cycle after capture, required 1", valid_out);
            end
        end
        if (src_q.size() > 0) begin
            rxf_n_in = 1'b0;
            data_in  = src_q[0].data;
            be_in    = src_q[0].be;
        end else begin
            rxf_n_in = !force_rxf;
            data_in  = 32'h0;
            be_in    = 4'h0;
        end
        force_rxf = 1'b0;
        take = (rd_n_out === 1'b0) && (rxf_n_in === 1'b0) && (src_q.size() > 0);
        xfer = (valid_out === 1'b1) && (ready_in === 1'b1);
        if (xfer) begin
            n_tests++;
            delivered++;
            last_be_out = be_out;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got be=%h data=%h, required none", be_out, data_out);
            end else begin
                exp_w = sb_q.pop_front();
                if ({be_out, data_out} !== {exp_w.be, exp_w.data}) begin
                    n_fail++;
                    $display("FAIL word_order: got be=%h data=%h, required be=%h data=%h",
                             be_out, data_out, exp_w.be, exp_w.data);
                end
            end
        end
        lat_pend = 1'b0;
        if (take) begin
            w = src_q.pop_front();
            taken++;
            if (w.be != 4'h0) begin
                sb_q.push_back(w);
                lat_pend = 1'b1;
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        ready_in = 1'b1;
        while ((src_q.size() > 0 || sb_q.size() > 0 || busy_out !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        n_tests++;
        if (src_q.size() > 0 || sb_q.size() > 0 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout: src=%0d pending=%0d busy=%b after %0d cycles, required empty",
                     src_q.size(), sb_q.size(), busy_out, n);
        end
    endtask

    task automatic check_idle_pins(input string name);
        n_tests++;
        if ({oe_n_out, rd_n_out, valid_out, busy_out} !== 4'b1100) begin
            n_fail++;
            $display("FAIL %s: oe_n=%b rd_n=%b valid=%b busy=%b, required 1 1 0 0",
                     name, oe_n_out, rd_n_out, valid_out, busy_out);
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        ready_in = 1'b0;
        repeat (3) tick();
        check_idle_pins("reset_pins");
        n_tests++;
        if ({be_out, data_out} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_data: be=%h data=%h, required 0 0", be_out, data_out);
        end
        rst_n_in = 1'b1;
        repeat (4) tick();
        check_idle_pins("post_release");
    endtask

    task automatic test_idle();
        ready_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_tests++;
            if ({oe_n_out, rd_n_out, valid_out} !== 3'b110) begin
                n_fail++;
                $display("FAIL idle_bus cycle %0d: oe_n=%b rd_n=%b valid=%b, required 1 1 0",
                         i, oe_n_out, rd_n_out, valid_out);
            end
        end
    endtask

    // Expected after each edge: TURN, 11x READ (10 captures + entry), STOP, IDLE.
    task automatic test_burst();
        logic e_oe;
        logic e_rd;
        logic e_busy;
        ready_in = 1'b1;
        for (int i = 0; i < 10; i++) src_q.push_back('{be: 4'hF, data: 32'(i)});
        lat_chk = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            e_oe   = (i == 13);
            e_rd   = (i == 0) || (i >= 12);
            e_busy = (i < 13);
            n_tests++;
            if ({oe_n_out, rd_n_out, busy_out} !== {e_oe, e_rd, e_busy}) begin
                n_fail++;
                $display("FAIL burst_seq cycle %0d: oe_n=%b rd_n=%b busy=%b, required %b %b %b",
                         i, oe_n_out, rd_n_out, busy_out, e_oe, e_rd, e_busy);
            end
        end
        lat_chk = 1'b0;
        drain(50);
    endtask

    task automatic test_turn_abort();
        int  t0;
        logic [1:0] exp_pins [4];
        exp_pins[0] = 2'b01;
        exp_pins[1] = 2'b00;
        exp_pins[2] = 2'b01;
        exp_pins[3] = 2'b11;
        t0 = taken;
        force_rxf = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if ({oe_n_out, rd_n_out, valid_out} !== {exp_pins[i], 1'b0}) begin
                n_fail++;
                $display("FAIL turn_abort cycle %0d: oe_n=%b rd_n=%b valid=%b, required %b 0",
                         i, oe_n_out, rd_n_out, valid_out, exp_pins[i]);
            end
        end
        n_tests++;
        if (taken != t0) begin
            n_fail++;
            $display("FAIL turn_abort_capture: %0d words taken, required 0", taken - t0);
        end
    endtask

    task automatic test_backpressure();
        int  t0;
        int  d0;
        int  n;
        bit  resumed;
        int  exp_taken;
        t0 = taken;
        ready_in = 1'b0;
        for (int i = 0; i < 40; i++) src_q.push_back('{be: 4'hF, data: 32'h100 + 32'(i)});
        repeat (40) tick();
        // The edge seeing free < STOP_MARGIN still captures one in-flight word.
        exp_taken = int'(FIFO_DEPTH) - int'(STOP_MARGIN) + 2;
        n_tests++;
        if (taken - t0 != exp_taken) begin
            n_fail++;
            $display("FAIL stop_fill: %0d words taken, required %0d", taken - t0, exp_taken);
        end
        n_tests++;
        if ({oe_n_out, rd_n_out, valid_out} !== 3'b111) begin
            n_fail++;
            $display("FAIL stop_pins: oe_n=%b rd_n=%b valid=%b, required 1 1 1",
                     oe_n_out, rd_n_out, valid_out);
        end
        ready_in = 1'b1;
        d0 = delivered;
        resumed = 1'b0;
        n = 0;
        while (delivered - d0 < int'(FIFO_DEPTH) && n < 100) begin
            tick();
            if (rd_n_out === 1'b0) resumed = 1'b1;
            n++;
        end
        n_tests++;
        if (delivered - d0 < int'(FIFO_DEPTH) || !resumed) begin
            n_fail++;
            $display("FAIL resume: delivered %0d resumed=%b, required %0d and 1",
                     delivered - d0, resumed, FIFO_DEPTH);
        end
        drain(300);
    endtask

    task automatic test_byte_enables();
        int d0;
        d0 = delivered;
        src_q.push_back('{be: 4'hF, data: 32'hA0});
        src_q.push_back('{be: 4'hF, data: 32'hA1});
        src_q.push_back('{be: 4'h0, data: 32'hA2});
        src_q.push_back('{be: 4'hF, data: 32'hA3});
        src_q.push_back('{be: 4'h3, data: 32'hA4});
        drain(50);
        n_tests++;
        if (delivered - d0 != 4 || last_be_out !== 4'h3) begin
            n_fail++;
            $display("FAIL be_drop: delivered %0d last be=%h, required 4 and 3",
                     delivered - d0, last_be_out);
        end
    endtask

    task automatic test_reset_mid_burst();
        int t0;
        int n;
        t0 = taken;
        ready_in = 1'b0;
        for (int i = 0; i < 20; i++) src_q.push_back('{be: 4'hF, data: 32'h200 + 32'(i)});
        n = 0;
        while (taken - t0 < 5 && n < 30) begin
            tick();
            n++;
        end
        n_tests++;
        if (rd_n_out !== 1'b0 || taken - t0 != 5) begin
            n_fail++;
            $display("FAIL mid_burst_setup: rd_n=%b taken=%0d, required 0 and 5", rd_n_out, taken - t0);
        end
        rst_n_in = 1'b0;
        #1;
        check_idle_pins("async_release");
        n_tests++;
        if ({be_out, data_out} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_flush: be=%h data=%h, required 0 0", be_out, data_out);
        end
        src_q.delete();
        sb_q.delete();
        repeat (2) tick();
        rst_n_in = 1'b1;
        repeat (4) tick();
        check_idle_pins("clean_restart");
        src_q.push_back('{be: 4'hF, data: 32'h300});
        src_q.push_back('{be: 4'hF, data: 32'h301});
        src_q.push_back('{be: 4'h7, data: 32'h302});
        drain(50);
`ifdef FT_RX_BYTE_COUNT_EN
        n_tests++;
        if (byte_count_out !== 32'd11) begin
            n_fail++;
            $display("FAIL byte_count: got %0d, required 11", byte_count_out);
        end
`endif
    endtask

    initial begin
        rst_n_in = 1'b0;
        rxf_n_in = 1'b1;
        data_in  = 32'h0;
        be_in    = 4'h0;
        ready_in = 1'b0;
        #1;
        test_reset();
        test_idle();
        test_burst();
        test_turn_abort();
        test_backpressure();
        test_byte_enables();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
